vending_machine_ctrl: RTL and testbench
=======================================

// Module: vending_machine_ctrl
// PURPOSE
//  Parametrised N-slot vending controller. Accepts quarter/dollar coins as edge-detected
//  pulses and tracks credit with a ceiling. Vends one-hot-selected slots with per-slot
//  stock, pricing and out-of-stock flags, and returns change one quarter per cycle via an FSM.
//  Sits between the coin/button front-end and the dispenser/coin-return actuators.
// PARAMETERS
//  N_PRODUCTS   4     number of product slots
//  STOCK_W      4     stock counter width; full stock STOCK_MAX = 2**STOCK_W-1
//  MONEY_W      12    credit register width (must hold MAX_CREDIT)
//  PRICE_STEP   25    slot i price = (i+1)*PRICE_STEP; must be a multiple of 25
//  MAX_CREDIT   1000  credit ceiling; coins that would exceed it are rejected
//  VEND_CYCLES  2     cycles product[i] is held high per vend (>=1)
//  AUTO_CHANGE  0     1: after a vend, leftover credit is returned automatically
// PORTS
//  clk           in   1           single clock, rising edge
//  reset         in   1           synchronous, active-low reset
//  quarter       in   1           coin sensor, level; rising edge = +25
//  dollar        in   1           coin sensor, level; rising edge = +100
//  select        in   N_PRODUCTS  one-hot slot select, sampled on buy edge
//  buy           in   1           buy button, level; rising edge = vend request
//  cancel        in   1           cancel button, level; rising edge = return credit
//  load          in   N_PRODUCTS  per-slot restock; bit i high sets stock_i = STOCK_MAX
//  money         out  MONEY_W     current credit
//  product       out  N_PRODUCTS  one-hot dispense strobe
//  out_of_stock  out  N_PRODUCTS  bit i = (stock_i == 0)
//  change_coin   out  1           one pulse = one quarter returned
//  coin_reject   out  1           1-cycle pulse: coin refused and returned
//  error         out  1           1-cycle pulse: buy refused
//  busy          out  1           high in VEND and CHANGE
// BEHAVIOUR
//  Reset (reset==0 at clk edge): money=0, product=0, change_coin=0, coin_reject=0, error=0,
//    busy=0, FSM=IDLE, all edge-detect regs=0, every stock=STOCK_MAX, out_of_stock=0.
//    Reset mid-VEND/CHANGE: remaining credit is discarded and no further pulses occur.
//  Edge detect: registered previous values of quarter/dollar/buy/cancel. A held level counts
//    once. Outputs update on the clk edge after the rising edge is sampled (1-cycle latency).
//  FSM states: IDLE, VEND, CHANGE.
//  IDLE priority when edges coincide: cancel > buy > coins. Coins are dropped (coin_reject)
//    only when a buy/cancel edge is acted on in the same cycle.
//   - coins: quarter and dollar edges in the same cycle are credited together. If
//     money+sum > MAX_CREDIT, the whole sum is refused: coin_reject=1 and money is unchanged.
//   - buy: refused (error=1, no other change) if select is not one-hot, the slot is empty,
//     or money < price. Otherwise money -= price, stock_i -= 1, enter VEND.
//   - cancel: if money>0, go to CHANGE; if money==0, take no action.
//  VEND: product = select captured at buy, held exactly VEND_CYCLES cycles (down-counter).
//    Then go to CHANGE if AUTO_CHANGE && money>0, else to IDLE.
//  CHANGE: each cycle change_coin=1 and money -= 25. Go to IDLE in the cycle money reaches 0.
//  Outside IDLE, any coin edge gives coin_reject=1 with credit unchanged. buy/cancel edges
//    are ignored.
//  Stock: load[i] acts in any state. Load and a decrement on the same slot in the same cycle:
//    load wins (stock=STOCK_MAX). Stock never wraps below 0. out_of_stock is decoded
//    combinationally from the stock registers.
//  Credit stays a multiple of 25 (prices/coins multiples of 25), so CHANGE always ends at 0.
//    Arithmetic is MONEY_W unsigned; overflow is impossible by the MAX_CREDIT check.
// TESTING
//  1 quarter,quarter,dollar edges from 0 -> money 25,50,150. select=0010, buy ->
//    product=0010 for 2 cycles, money=100, stock1=14, busy high 2 cycles.
//  2 money=25, select=1000, buy -> error pulse, money=25, product=0. select=0011, buy -> error.
//  3 15 paid vends of slot0 -> out_of_stock[0]=1. 16th buy -> error. load=0001 ->
//    out_of_stock[0]=0, stock0=15.
//  4 money=75, cancel -> change_coin high 3 consecutive cycles, money 50,25,0, then IDLE.
//    AUTO_CHANGE=1, money 100, buy slot0 -> 3 change pulses after VEND.
//  5 money=950, dollar -> coin_reject, money=950. From 0, quarter+dollar same cycle ->
//    money=125. quarter held 10 cycles -> +25 once.
//  6 reset=0 during CHANGE at money=50 -> next cycle money=0, change_coin=0, state IDLE,
//    all stock=15.

Source files
------------

// File: rtl/vending_machine_ctrl.sv
// vending_machine_ctrl: N-slot vending controller. Edge-detects coin and
// button levels, keeps a capped credit balance, dispenses one-hot selected
// slots with per-slot stock, and pays change back one quarter per cycle.
module vending_machine_ctrl #(
  parameter int N_PRODUCTS  = 4,
  parameter int STOCK_W     = 4,
  parameter int MONEY_W     = 12,
  parameter int PRICE_STEP  = 25,
  parameter int MAX_CREDIT  = 1000,
  parameter int VEND_CYCLES = 2,
  parameter int AUTO_CHANGE = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  quarter,
  input  logic                  dollar,
  input  logic [N_PRODUCTS-1:0] select,
  input  logic                  buy,
  input  logic                  cancel,
  input  logic [N_PRODUCTS-1:0] load,
  output logic [MONEY_W-1:0]    money,
  output logic [N_PRODUCTS-1:0] product,
  output logic [N_PRODUCTS-1:0] out_of_stock,
  output logic                  change_coin,
  output logic                  coin_reject,
  output logic                  error,
  output logic                  busy
);

  localparam int IDX_W = (N_PRODUCTS > 1) ? $clog2(N_PRODUCTS) : 1;
  localparam int CNT_W = $clog2(VEND_CYCLES + 1);
  localparam logic [STOCK_W-1:0] STOCK_MAX = {STOCK_W{1'b1}};
  localparam logic [MONEY_W:0] QUARTER_W = (MONEY_W+1)'(25);
  localparam logic [MONEY_W:0] DOLLAR_W = (MONEY_W+1)'(100);
  localparam logic [MONEY_W:0] CEILING = (MONEY_W+1)'(MAX_CREDIT);
  localparam logic [MONEY_W-1:0] QUARTER = MONEY_W'(25);
  localparam logic [CNT_W-1:0] VEND_LAST = CNT_W'(VEND_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

  state_t state;
  logic quarter_q, dollar_q, buy_q, cancel_q;
  logic quarter_e, dollar_e, buy_e, cancel_e;
  logic [STOCK_W-1:0] stock [N_PRODUCTS];
  logic [CNT_W-1:0] vend_cnt;
  logic [IDX_W-1:0] sel_idx;
  logic [MONEY_W-1:0] price;
  logic [MONEY_W:0] coin_sum;
  logic coin_any, coin_fits, cancel_act, buy_ok, vend_go;

  assign busy = (state != IDLE);

  // Decode edges, selected slot, price and whether a coin or buy can be accepted.
  always_comb begin
    quarter_e  = quarter & ~quarter_q;
    dollar_e   = dollar & ~dollar_q;
    buy_e      = buy & ~buy_q;
    cancel_e   = cancel & ~cancel_q;
    sel_idx    = '0;
    for (int i = 0; i < N_PRODUCTS; i++) begin
      if (select[i]) sel_idx = IDX_W'(i);
    end
    price      = MONEY_W'((int'(sel_idx) + 1) * PRICE_STEP);
    coin_sum   = (quarter_e ? QUARTER_W : '0) + (dollar_e ? DOLLAR_W : '0);
    coin_any   = quarter_e | dollar_e;
    coin_fits  = ({1'b0, money} + coin_sum) <= CEILING;
    cancel_act = cancel_e && (money != '0);
    buy_ok     = $onehot(select) && (stock[sel_idx] != '0) && (money >= price);
    vend_go    = (state == IDLE) && !cancel_act && buy_e && buy_ok;
    for (int i = 0; i < N_PRODUCTS; i++) begin
      out_of_stock[i] = (stock[i] == '0);
    end
  end

  // Remember last input levels so a held level only counts once.
  always_ff @(posedge clk) begin
    if (!reset) begin
      quarter_q <= 1'b0;
      dollar_q  <= 1'b0;
      buy_q     <= 1'b0;
      cancel_q  <= 1'b0;
    end else begin
      quarter_q <= quarter;
      dollar_q  <= dollar;
      buy_q     <= buy;
      cancel_q  <= cancel;
    end
  end

  // Per-slot stock: restock wins over a same-cycle vend decrement.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N_PRODUCTS; i++) stock[i] <= STOCK_MAX;
    end else begin
      for (int i = 0; i < N_PRODUCTS; i++) begin
        if (load[i])
          stock[i] <= STOCK_MAX;
        else if (vend_go && (sel_idx == IDX_W'(i)) && (stock[i] != '0))
          stock[i] <= stock[i] - 1'b1;
      end
    end
  end

  // Main controller: credit, vend strobe timing and quarter-by-quarter change.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      money       <= '0;
      product     <= '0;
      vend_cnt    <= '0;
      change_coin <= 1'b0;
      coin_reject <= 1'b0;
      error       <= 1'b0;
    end else begin
      change_coin <= 1'b0;
      coin_reject <= 1'b0;
      error       <= 1'b0;
      case (state)
        IDLE: begin
          if (cancel_act) begin
            coin_reject <= coin_any;
            state       <= CHANGE;
          end else if (buy_e) begin
            coin_reject <= coin_any;
            if (buy_ok) begin
              money    <= money - price;
              product  <= select;
              vend_cnt <= VEND_LAST;
              state    <= VEND;
            end else begin
              error <= 1'b1;
            end
          end else if (coin_any) begin
            if (coin_fits) money <= money + coin_sum[MONEY_W-1:0];
            else coin_reject <= 1'b1;
          end
        end
        VEND: begin
          coin_reject <= coin_any;
          if (vend_cnt == '0) begin
            product <= '0;
            if ((AUTO_CHANGE != 0) && (money != '0)) state <= CHANGE;
            else state <= IDLE;
          end else begin
            vend_cnt <= vend_cnt - 1'b1;
          end
        end
        CHANGE: begin
          coin_reject <= coin_any;
          if (money >= QUARTER) begin
            money       <= money - QUARTER;
            change_coin <= 1'b1;
            if (money == QUARTER) state <= IDLE;
          end else begin
            money <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vending_machine_ctrl.sv
// tb_vending_machine_ctrl: directed test of the vending controller, with a
// second instance built for automatic change return sharing the same inputs.
module tb_vending_machine_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic quarter = 1'b0, dollar = 1'b0, buy = 1'b0, cancel = 1'b0;
  logic [3:0] select = '0, load = '0;

  logic [11:0] money, money_a;
  logic [3:0] product, product_a, out_of_stock, out_of_stock_a;
  logic change_coin, change_coin_a, coin_reject, coin_reject_a;
  logic error, error_a, busy, busy_a;

  int checks = 0;
  int errors = 0;

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  vending_machine_ctrl dut (
    .clk(clk), .reset(reset), .quarter(quarter), .dollar(dollar),
    .select(select), .buy(buy), .cancel(cancel), .load(load),
    .money(money), .product(product), .out_of_stock(out_of_stock),
    .change_coin(change_coin), .coin_reject(coin_reject), .error(error),
    .busy(busy)
  );

  vending_machine_ctrl #(.AUTO_CHANGE(1)) dut_auto (
    .clk(clk), .reset(reset), .quarter(quarter), .dollar(dollar),
    .select(select), .buy(buy), .cancel(cancel), .load(load),
    .money(money_a), .product(product_a), .out_of_stock(out_of_stock_a),
    .change_coin(change_coin_a), .coin_reject(coin_reject_a), .error(error_a),
    .busy(busy_a)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic applyStimulus(input logic q, input logic d, input logic b, input logic c,
                               input logic [3:0] sel, input logic [3:0] ld);
    quarter = q; dollar = d; buy = b; cancel = c; select = sel; load = ld;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 0, 4'b0000, 4'b0000);
  endtask

  task automatic doReset();
    reset = 1'b0;
    idleCycle();
    idleCycle();
    reset = 1'b1;
  endtask

  initial begin
    int cnt;
    $display("[TB] start");
    doReset();
    checkOutput("reset_money", money, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_oos", out_of_stock, 0);
    checkOutput("reset_product", product, 0);

    // coins and a vend of slot1 (price 50)
    applyStimulus(1, 0, 0, 0, 4'b0000, 4'b0000); checkOutput("q1_money", money, 25);
    idleCycle();
    applyStimulus(1, 0, 0, 0, 4'b0000, 4'b0000); checkOutput("q2_money", money, 50);
    idleCycle();
    applyStimulus(0, 1, 0, 0, 4'b0000, 4'b0000); checkOutput("d_money", money, 150);
    idleCycle();
    applyStimulus(0, 0, 1, 0, 4'b0010, 4'b0000);
    checkOutput("vend1_product", product, 4'b0010);
    checkOutput("vend1_busy", busy, 1);
    checkOutput("vend1_money", money, 100);
    applyStimulus(0, 0, 0, 0, 4'b0010, 4'b0000);
    checkOutput("vend2_product", product, 4'b0010);
    checkOutput("vend2_busy", busy, 1);
    idleCycle();
    checkOutput("vend_done_product", product, 0);
    checkOutput("vend_done_busy", busy, 0);

    // drain the 100 left so the refusal tests start from a known 25
    applyStimulus(0, 0, 0, 1, 4'b0000, 4'b0000);
    cnt = 0;
    do begin idleCycle(); cnt++; end while ((busy || change_coin) && cnt < 20);
    checkOutput("drain_timeout", (cnt < 20) ? 1 : 0, 1);
    checkOutput("drain_money", money, 0);

    // refused buys
    applyStimulus(1, 0, 0, 0, 4'b0000, 4'b0000); idleCycle();
    applyStimulus(0, 0, 1, 0, 4'b1000, 4'b0000);
    checkOutput("poor_error", error, 1);
    checkOutput("poor_money", money, 25);
    checkOutput("poor_product", product, 0);
    idleCycle();
    checkOutput("error_pulse", error, 0);
    applyStimulus(0, 0, 1, 0, 4'b0011, 4'b0000);
    checkOutput("multisel_error", error, 1);
    checkOutput("multisel_busy", busy, 0);
    idleCycle();

    // empty slot0 with 15 paid vends
    for (int i = 0; i < 15; i++) begin
      applyStimulus(0, 0, 1, 0, 4'b0001, 4'b0000);
      applyStimulus(0, 0, 0, 0, 4'b0001, 4'b0000);
      idleCycle();
      if (i == 13) checkOutput("oos_after14", out_of_stock[0], 0);
      applyStimulus(1, 0, 0, 0, 4'b0000, 4'b0000);
      idleCycle();
    end
    checkOutput("oos_after15", out_of_stock, 4'b0001);
    checkOutput("money_after15", money, 25);
    applyStimulus(0, 0, 1, 0, 4'b0001, 4'b0000);
    checkOutput("empty_error", error, 1);
    checkOutput("empty_money", money, 25);
    idleCycle();
    applyStimulus(0, 0, 0, 0, 4'b0000, 4'b0001);
    checkOutput("load_oos", out_of_stock, 0);
    idleCycle();

    // cancel 75 -> three change pulses, coin during CHANGE rejected
    applyStimulus(1, 0, 0, 0, 4'b0000, 4'b0000); idleCycle();
    applyStimulus(1, 0, 0, 0, 4'b0000, 4'b0000); idleCycle();
    checkOutput("pre_cancel_money", money, 75);
    applyStimulus(0, 0, 0, 1, 4'b0000, 4'b0000);
    checkOutput("cancel_busy", busy, 1);
    checkOutput("cancel_chg0", change_coin, 0);
    idleCycle();
    checkOutput("chg1", change_coin, 1); checkOutput("chg1_money", money, 50);
    applyStimulus(1, 0, 0, 0, 4'b0000, 4'b0000);
    checkOutput("chg2", change_coin, 1); checkOutput("chg2_money", money, 25);
    checkOutput("busy_coin_reject", coin_reject, 1);
    idleCycle();
    checkOutput("chg3", change_coin, 1); checkOutput("chg3_money", money, 0);
    idleCycle();
    checkOutput("chg_end", change_coin, 0);
    checkOutput("chg_end_busy", busy, 0);

    // automatic change after a vend: 100 - 25 leaves three quarters
    doReset();
    applyStimulus(0, 1, 0, 0, 4'b0000, 4'b0000); idleCycle();
    applyStimulus(0, 0, 1, 0, 4'b0001, 4'b0000);
    checkOutput("auto_product", product_a, 4'b0001);
    applyStimulus(0, 0, 0, 0, 4'b0001, 4'b0000);
    idleCycle();
    checkOutput("auto_busy", busy_a, 1);
    checkOutput("auto_chg0", change_coin_a, 0);
    checkOutput("plain_idle_money", money, 75);
    checkOutput("plain_idle_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      idleCycle();
      checkOutput("auto_chg", change_coin_a, 1);
      checkOutput("auto_chg_money", money_a, 50 - 25 * i);
    end
    idleCycle();
    checkOutput("auto_chg_end", change_coin_a, 0);
    checkOutput("plain_no_change", change_coin, 0);

    // credit ceiling
    doReset();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(0, 1, 0, 0, 4'b0000, 4'b0000); idleCycle();
    end
    applyStimulus(1, 0, 0, 0, 4'b0000, 4'b0000); idleCycle();
    applyStimulus(1, 0, 0, 0, 4'b0000, 4'b0000); idleCycle();
    checkOutput("money_950", money, 950);
    applyStimulus(0, 1, 0, 0, 4'b0000, 4'b0000);
    checkOutput("ceiling_reject", coin_reject, 1);
    checkOutput("ceiling_money", money, 950);
    idleCycle();
    checkOutput("reject_pulse", coin_reject, 0);

    // simultaneous coins and a held quarter
    doReset();
    applyStimulus(1, 1, 0, 0, 4'b0000, 4'b0000);
    checkOutput("both_coins", money, 125);
    idleCycle();
    for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 0, 4'b0000, 4'b0000);
    checkOutput("held_quarter", money, 150);
    idleCycle();

    // reset while returning change at 50
    applyStimulus(0, 0, 0, 1, 4'b0000, 4'b0000);
    for (int i = 0; i < 4; i++) idleCycle();
    checkOutput("pre_reset_money", money, 50);
    checkOutput("pre_reset_chg", change_coin, 1);
    reset = 1'b0;
    idleCycle();
    checkOutput("rst_money", money, 0);
    checkOutput("rst_chg", change_coin, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_oos", out_of_stock, 0);
    reset = 1'b1;
    idleCycle();
    idleCycle();
    checkOutput("rst_no_pulse", change_coin, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
